instr_decoder: RTL and testbench
================================

// Module: instr_decoder
// PURPOSE
// - MIPS-subset instruction decoder for the pipelined CPU; translates op/func into one-hot instruction flags and control fields.
// - Decode path is combinational and feeds D-stage control.
// - Carries one pipeline register of op/func so the next stage (E) gets the registered instruction and its Tnew for hazard logic.
// PARAMETERS
// - none; encodings below are fixed.
// PORTS
// clk         in   1  rising-edge clock
// reset       in   1  synchronous, active-high reset
// en          in   1  pipeline-register load enable; 0 = hold (stall)
// op          in   6  instr[31:26]
// func        in   6  instr[5:0]
// addu,subu,ori,lui,lw,sw,beq,j,jal,jr  out 1 each  one-hot comb instruction flags
// undef       out  1  no flag set (incl. nop 0x00000000)
// reg_write   out  1  addu|subu|ori|lui|lw|jal
// reg_dst     out  2  00 rt, 01 rd (addu/subu), 10 $31 (jal)
// alu_src     out  1  1 = ext imm (ori|lui|lw|sw)
// alu_ctr     out  3  000 ADDU, 001 SUBU (subu), 010 OR (ori), 011 LUI (lui); all others 000
// ext_op      out  1  1 = sign-extend (lw|sw|beq); 0 = zero-extend
// mem_write   out  1  sw
// mem_to_reg  out  2  00 ALU, 01 DM (lw), 10 PC+8 (jal)
// npc_sel     out  2  00 PC+4, 01 beq target, 10 j/jal target, 11 jr (rs)
// op_q        out  6  registered op
// func_q      out  6  registered func
// tnew_q      out  2  Tnew of registered instr: 01 ALU, 10 DM, 00 other
// BEHAVIOUR
// - Encodings: R-type op=000000 with func addu=100001, subu=100011, jr=001000.
//   ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
// - func is examined only when op==000000; e.g. op=100011 is lw whatever func holds.
// - R-type with an unlisted func, or any unlisted op -> all flags 0, undef=1, and all control fields 0.
// - Every comb output depends only on op/func (zero latency), independent of clk/reset/en.
// - Exactly one instruction flag is high for each legal encoding.
// - Rising clk edge:
//   - reset=1 -> op_q=0, func_q=0 (reset overrides en).
//   - else en=1 -> op_q<=op, func_q<=func.
//   - else (en=0) -> hold.
// - tnew_q is decoded combinationally from op_q/func_q with the same encoding rules:
//   - 01 for addu/subu/ori/lui;
//   - 10 for lw;
//   - 00 for sw/beq/j/jal/jr/undef.
// - After reset, tnew_q=00 (op_q/func_q=0 decodes as undef).
// - No internal state besides op_q/func_q; no handshake.
// CONFIGURATION
// - Macro DECODER_TNEW_EN:
//   - Defined: tnew_q behaves as specified above.
//   - Undefined: tnew_q is tied to 2'b00 and the second decode of op_q/func_q is not built; op_q/func_q still register normally.
// TESTING
// - op=000000, func=100001 -> addu=1, reg_write=1, reg_dst=01, alu_ctr=000, npc_sel=00, undef=0.
// - op=100011, func=100001 -> lw=1, addu=0, alu_src=1, ext_op=1, mem_to_reg=01; next edge (en=1) -> tnew_q=10.
// - op=000011 -> jal=1, reg_dst=10, mem_to_reg=10, npc_sel=10; after clock, tnew_q=00.
// - op=000000, func=000000 -> undef=1, all flags and control fields 0.
// - ori loaded (tnew_q=01), then en=0 with op=lw -> op_q/func_q/tnew_q unchanged.
// - Assert reset with en=1, op=ori -> op_q=0, func_q=0, tnew_q=00 next edge.

Source files
------------

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - MIPS-subset op/func decoder with one op/func pipeline register
// Optional macro DECODER_TNEW_EN builds the Tnew decode of the registered instruction.
module instr_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [5:0] op,
   input  logic [5:0] func,
   output logic       addu,
   output logic       subu,
   output logic       ori,
   output logic       lui,
   output logic       lw,
   output logic       sw,
   output logic       beq,
   output logic       j,
   output logic       jal,
   output logic       jr,
   output logic       undef,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic       alu_src,
   output logic [2:0] alu_ctr,
   output logic       ext_op,
   output logic       mem_write,
   output logic [1:0] mem_to_reg,
   output logic [1:0] npc_sel,
   output logic [5:0] op_q,
   output logic [5:0] func_q,
   output logic [1:0] tnew_q
);

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] FN_ADDU   = 6'b100001;
   localparam logic [5:0] FN_SUBU   = 6'b100011;
   localparam logic [5:0] FN_JR     = 6'b001000;

   logic r_type;

   // func is only meaningful for R-type, so every R-type flag is gated by r_type
   always_comb begin
      r_type = (op == OP_RTYPE);
      addu   = r_type && (func == FN_ADDU);
      subu   = r_type && (func == FN_SUBU);
      jr     = r_type && (func == FN_JR);
      ori    = (op == OP_ORI);
      lui    = (op == OP_LUI);
      lw     = (op == OP_LW);
      sw     = (op == OP_SW);
      beq    = (op == OP_BEQ);
      j      = (op == OP_J);
      jal    = (op == OP_JAL);
      undef  = !(addu || subu || ori || lui || lw || sw || beq || j || jal || jr);
   end

   always_comb begin
      reg_write  = addu | subu | ori | lui | lw | jal;
      reg_dst    = {jal, addu | subu};
      alu_src    = ori | lui | lw | sw;
      alu_ctr    = {1'b0, ori | lui, subu | lui};
      ext_op     = lw | sw | beq;
      mem_write  = sw;
      mem_to_reg = {jal, lw};
      npc_sel    = {j | jal | jr, beq | jr};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= 6'd0;
         func_q <= 6'd0;
      end else if (en) begin
         op_q   <= op;
         func_q <= func;
      end
   end

`ifdef DECODER_TNEW_EN
   logic alu_q;
   logic lw_q;

   always_comb begin
      alu_q = ((op_q == OP_RTYPE) && ((func_q == FN_ADDU) || (func_q == FN_SUBU)))
              || (op_q == OP_ORI) || (op_q == OP_LUI);
      lw_q  = (op_q == OP_LW);
      tnew_q = lw_q ? 2'b10 : (alu_q ? 2'b01 : 2'b00);
   end
`else
   assign tnew_q = 2'b00;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - directed plus random checks of instr_decoder against a table model
module tb_instr_decoder;

   logic       clk = 1'b0;
   logic       reset, en;
   logic [5:0] op, func;
   logic       addu, subu, ori, lui, lw, sw, beq, j, jal, jr, undef;
   logic       reg_write, alu_src, ext_op, mem_write;
   logic [1:0] reg_dst, mem_to_reg, npc_sel, tnew_q;
   logic [2:0] alu_ctr;
   logic [5:0] op_q, func_q;

   int errors = 0;
   int checks = 0;
   logic [5:0] m_op_q = 6'd0;
   logic [5:0] m_func_q = 6'd0;

   always #5 clk = ~clk;

   instr_decoder dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .func(func),
      .addu(addu), .subu(subu), .ori(ori), .lui(lui), .lw(lw), .sw(sw),
      .beq(beq), .j(j), .jal(jal), .jr(jr), .undef(undef),
      .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
      .alu_ctr(alu_ctr), .ext_op(ext_op), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .npc_sel(npc_sel),
      .op_q(op_q), .func_q(func_q), .tnew_q(tnew_q)
   );

   // instruction index: 0 addu .. 9 jr, 10 undefined
   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'd0) begin
         if (f == 6'd33) return 0;
         if (f == 6'd35) return 1;
         if (f == 6'd8)  return 9;
         return 10;
      end
      case (o)
         6'd13: return 2;
         6'd15: return 3;
         6'd35: return 4;
         6'd43: return 5;
         6'd4:  return 6;
         6'd2:  return 7;
         6'd3:  return 8;
         default: return 10;
      endcase
   endfunction

   // {flags[9:0], undef, reg_write, reg_dst, alu_src, alu_ctr, ext_op, mem_write, mem_to_reg, npc_sel}
   function automatic logic [23:0] expect_comb(input logic [5:0] o, input logic [5:0] f);
      int id = classify(o, f);
      logic [9:0] flags = (id < 10) ? (10'b1000000000 >> id) : 10'b0;
      logic rw = 0, as = 0, ex = 0, mw = 0;
      logic [1:0] rd = 0, mtr = 0, ns = 0;
      logic [2:0] ac = 0;
      case (id)
         0: begin rw = 1; rd = 1; end
         1: begin rw = 1; rd = 1; ac = 1; end
         2: begin rw = 1; as = 1; ac = 2; end
         3: begin rw = 1; as = 1; ac = 3; end
         4: begin rw = 1; as = 1; ex = 1; mtr = 1; end
         5: begin as = 1; ex = 1; mw = 1; end
         6: begin ex = 1; ns = 1; end
         7: ns = 2;
         8: begin rw = 1; rd = 2; mtr = 2; ns = 2; end
         9: ns = 3;
         default: ;
      endcase
      return {flags, id == 10, rw, rd, as, ac, ex, mw, mtr, ns};
   endfunction

   function automatic logic [1:0] expect_tnew(input logic [5:0] o, input logic [5:0] f);
`ifdef DECODER_TNEW_EN
      int id = classify(o, f);
      if (id <= 3) return 2'b01;
      if (id == 4) return 2'b10;
      return 2'b00;
`else
      return 2'b00;
`endif
   endfunction

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // apply inputs mid-cycle, check comb outputs, then clock and check the register side
   task automatic step(input logic r, input logic e, input logic [5:0] o, input logic [5:0] f);
      @(negedge clk);
      reset = r; en = e; op = o; func = f;
      #1;
      check("comb", {addu, subu, ori, lui, lw, sw, beq, j, jal, jr, undef, reg_write,
                     reg_dst, alu_src, alu_ctr, ext_op, mem_write, mem_to_reg, npc_sel},
            expect_comb(o, f));
      @(posedge clk);
      if (r) begin m_op_q = 0; m_func_q = 0; end
      else if (e) begin m_op_q = o; m_func_q = f; end
      #1;
      check("op_q", {18'd0, op_q}, {18'd0, m_op_q});
      check("func_q", {18'd0, func_q}, {18'd0, m_func_q});
      check("tnew_q", {22'd0, tnew_q}, {22'd0, expect_tnew(m_op_q, m_func_q)});
   endtask

   logic [5:0] legal_ops [8] = '{6'd0, 6'd13, 6'd15, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3};
   logic [5:0] legal_fns [3] = '{6'd33, 6'd35, 6'd8};

   initial begin
      reset = 1; en = 0; op = 0; func = 0;
      step(1, 0, 6'd0, 6'd0);
      check("reset_tnew", {22'd0, tnew_q}, 24'd0);
      step(0, 1, 6'b000000, 6'b100001);
      step(0, 1, 6'b100011, 6'b100001);
      step(0, 1, 6'b000011, 6'b010101);
      step(0, 1, 6'b000000, 6'b000000);
      step(0, 1, 6'b001101, 6'b000000);
      step(0, 0, 6'b100011, 6'b000000);
      step(1, 1, 6'b001101, 6'b111111);
      step(0, 1, 6'b000000, 6'b100011);
      step(0, 1, 6'b000000, 6'b001000);
      step(0, 1, 6'b001111, 6'b001000);
      step(0, 1, 6'b101011, 6'b000000);
      step(0, 1, 6'b000100, 6'b000000);
      step(0, 1, 6'b000010, 6'b000000);
      step(0, 1, 6'b111111, 6'b100001);
      for (int i = 0; i < 300; i++) begin
         logic [5:0] o, f;
         o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 2)];
         step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, o, f);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
